writeback_stage: RTL
====================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter PEND_W, default 2, width of each per-register pending-write counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 SHALL have port memValid  input  1  MEM stage holds a valid instruction.
REQ-005 SHALL have port memRegWrite  input  1  instruction writes a register.
REQ-006 SHALL have port memMemToReg  input  1  1 = write load data, 0 = write ALU result.
REQ-007 SHALL have port memWriteRegister  input  5  destination register number.
REQ-008 SHALL have port memAluResult  input  32  ALU result from MEM stage.
REQ-009 SHALL have port memReadData  input  32  data-memory load data.
REQ-010 SHALL have port flush  input  1  squash the instruction entering WB this cycle.
REQ-011 SHALL have port issueValid  input  1  ID stage attempts to issue an instruction.
REQ-012 SHALL have port issueRegWrite  input  1  issuing instruction writes a register.
REQ-013 SHALL have port issueDest  input  5  issuing instruction's destination register.
REQ-014 SHALL have ports idRs, idRt  input  5 each  source registers of the ID instruction.
REQ-015 SHALL have ports idUsesRs, idUsesRt  input  1 each  source actually read.
REQ-016 SHALL have port regWrite  output  1  register-file write enable.
REQ-017 SHALL have port writeRegister  output  5  register-file write address.
REQ-018 SHALL have port writeData  output  32  register-file write data.
REQ-019 SHALL have port stall  output  1  ID must hold; issue not accepted.
REQ-020 SHALL have port retireCount  output  32  count of completed register writes.
REQ-021 SHALL have port scoreError  output  1  sticky pending-counter overflow/underflow flag.

Function
REQ-022 SHALL capture memValid, memRegWrite, memMemToReg, memWriteRegister, memAluResult, memReadData into a MEM/WB register on each rising clk; latency MEM->write port exactly 1 cycle.
REQ-023 SHALL capture valid as 0 when flush=1; flushed entry produces no write and no retire.
REQ-024 SHALL drive regWrite = wbValid & wbRegWrite & (wbWriteRegister != 0); writes to register 0 suppressed.
REQ-025 SHALL drive writeData = wbMemToReg ? wbReadData : wbAluResult, held stable for the whole cycle so the negedge-written register file samples settled data.
REQ-026 SHALL drive writeRegister = wbWriteRegister whenever valid; value don't-care when regWrite=0.
REQ-027 SHALL keep 32 PEND_W-bit pending counters, pend[0] hard-wired 0.
REQ-028 SHALL define accept = issueValid & ~stall & issueRegWrite & (issueDest != 0); accept increments pend[issueDest] at the clock edge.
REQ-029 SHALL decrement pend[writeRegister] at the edge ending any cycle with regWrite=1.
REQ-030 SHALL leave a counter unchanged when increment and decrement target the same register in the same cycle.
REQ-031 SHALL saturate at 2^PEND_W-1 on increment and at 0 on decrement, setting scoreError=1 in either case; scoreError stays 1 until reset.
REQ-032 SHALL compute, per source s in {Rs, Rt}: eff[s] = pend[s] minus 1 if regWrite=1 and writeRegister=s, else pend[s] (same-cycle writeback bypass via negedge write).
REQ-033 SHALL assert stall combinationally when (idUsesRs & idRs!=0 & eff[Rs]!=0) or (idUsesRt & idRt!=0 & eff[Rt]!=0); stall is independent of issueValid.
REQ-034 SHALL increment retireCount by 1 at each edge ending a cycle with regWrite=1; wraps 0xFFFFFFFF -> 0.
REQ-035 SHALL give reset priority over flush, issue and retire in the same cycle.

Reset
REQ-036 SHALL, on reset=1 at a rising edge, clear wbValid and all MEM/WB fields, all pend counters, retireCount and scoreError; in-flight writes are dropped.
REQ-037 SHALL show after reset: regWrite=0, writeRegister=0, writeData=0, stall=0, retireCount=0, scoreError=0.

Verification
REQ-038 SHALL cover: MEM valid, regWrite, dest=5, memToReg=0, alu=0x1234 -> next cycle regWrite=1, writeRegister=5, writeData=0x1234, retireCount=1.
REQ-039 SHALL cover: load with memToReg=1, readData=0xDEADBEEF, dest=0 -> regWrite=0, retireCount unchanged.
REQ-040 SHALL cover: issue dest=8, then ID reads idRs=8 -> stall=1 until the cycle regWrite=1 with writeRegister=8, where stall=0; afterwards pend[8]=0.
REQ-041 SHALL cover: flush=1 with valid dest=9 -> no write, pend[9] stays 1, ID reading R9 remains stalled.
REQ-042 SHALL cover: four accepted issues to dest=3 with no retire (PEND_W=2) -> pend[3]=3, scoreError=1.
REQ-043 SHALL cover: reset asserted mid-stream with pend[4]=2 and a valid WB entry -> next cycle regWrite=0, stall=0 for idRs=4, retireCount=0.

Source files
------------

// File: rtl/writeback_stage.sv
// Writeback stage: the MEM/WB pipeline register, the register-file write port,
// a per-register pending-write scoreboard that drives the ID stall, and a
// counter of retired register writes.
module writeback_stage #(
    parameter int PEND_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memValid,
    input  logic        memRegWrite,
    input  logic        memMemToReg,
    input  logic [4:0]  memWriteRegister,
    input  logic [31:0] memAluResult,
    input  logic [31:0] memReadData,
    input  logic        flush,
    input  logic        issueValid,
    input  logic        issueRegWrite,
    input  logic [4:0]  issueDest,
    input  logic [4:0]  idRs,
    input  logic [4:0]  idRt,
    input  logic        idUsesRs,
    input  logic        idUsesRt,
    output logic        regWrite,
    output logic [4:0]  writeRegister,
    output logic [31:0] writeData,
    output logic        stall,
    output logic [31:0] retireCount,
    output logic        scoreError
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    // MEM/WB pipeline register
    logic        wb_valid_q, wb_valid_d;
    logic        wb_reg_write_q;
    logic        wb_mem_to_reg_q;
    logic [4:0]  wb_write_register_q;
    logic [31:0] wb_alu_result_q;
    logic [31:0] wb_read_data_q;

    // Scoreboard and retire state
    logic [PEND_W-1:0] pend_q [32];
    logic [PEND_W-1:0] pend_d [32];
    logic              score_error_q, score_error_d;
    logic [31:0]       retire_count_q, retire_count_d;

    logic              accept;
    logic [PEND_W-1:0] eff_rs, eff_rt;

    // A squashed instruction still loads its fields but enters WB as invalid.
    assign wb_valid_d = memValid & ~flush;

    // Write port is driven purely from registered state so it is stable for
    // the whole cycle and the negedge-written register file sees settled data.
    assign regWrite      = wb_valid_q & wb_reg_write_q & (wb_write_register_q != 5'd0);
    assign writeRegister = wb_write_register_q;
    assign writeData     = wb_mem_to_reg_q ? wb_read_data_q : wb_alu_result_q;

    assign retireCount = retire_count_q;
    assign scoreError  = score_error_q;

    // Effective pending count per source, crediting a write retiring this cycle
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        eff_rs = pend_q[idRs];
        eff_rt = pend_q[idRt];
        // The negedge register-file write makes this cycle's writeback visible
        // to the ID read; the credit never goes below zero.
        if (regWrite && (writeRegister == idRs) && (eff_rs != '0)) begin
            eff_rs = eff_rs - PEND_ONE;
        end
        if (regWrite && (writeRegister == idRt) && (eff_rt != '0)) begin
            eff_rt = eff_rt - PEND_ONE;
        end
        stall = (idUsesRs && (idRs != 5'd0) && (eff_rs != '0)) ||
                (idUsesRt && (idRt != 5'd0) && (eff_rt != '0));
    end

    assign accept = issueValid & ~stall & issueRegWrite & (issueDest != 5'd0);

    // Next state of the pending counters and the sticky error flag
    always_comb begin
        score_error_d = score_error_q;
        for (int i = 0; i < 32; i++) begin
            pend_d[i] = pend_q[i];
            if (i == 0) begin
                pend_d[i] = '0;
            end else if (accept && (issueDest == 5'(i)) &&
                         !(regWrite && (writeRegister == 5'(i)))) begin
                if (pend_q[i] == PEND_MAX) begin
                    score_error_d = 1'b1;
                end else begin
                    pend_d[i] = pend_q[i] + PEND_ONE;
                end
            end else if (regWrite && (writeRegister == 5'(i)) &&
                         !(accept && (issueDest == 5'(i)))) begin
                if (pend_q[i] == '0) begin
                    score_error_d = 1'b1;
                end else begin
                    pend_d[i] = pend_q[i] - PEND_ONE;
                end
            end
        end
    end

    // Retire counter advances once per completed register write, wrapping
    assign retire_count_d = regWrite ? retire_count_q + 32'd1 : retire_count_q;

    // State register: reset wins over flush, issue and retire
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            wb_valid_q          <= 1'b0;
            wb_reg_write_q      <= 1'b0;
            wb_mem_to_reg_q     <= 1'b0;
            wb_write_register_q <= 5'd0;
            wb_alu_result_q     <= 32'd0;
            wb_read_data_q      <= 32'd0;
            score_error_q       <= 1'b0;
            retire_count_q      <= 32'd0;
            // NOTE: the counter array is reset explicitly; stale counts would stall ID forever.
            for (int i = 0; i < 32; i++) begin
                pend_q[i] <= '0;
            end
        end else begin
            wb_valid_q          <= wb_valid_d;
            wb_reg_write_q      <= memRegWrite;
            wb_mem_to_reg_q     <= memMemToReg;
            wb_write_register_q <= memWriteRegister;
            wb_alu_result_q     <= memAluResult;
            wb_read_data_q      <= memReadData;
            score_error_q       <= score_error_d;
            retire_count_q      <= retire_count_d;
            for (int i = 0; i < 32; i++) begin
                pend_q[i] <= pend_d[i];
            end
        end
    end

endmodule
